// File: rtl/epmp_hw_stack_pkg.sv
// Shared EPMP stack definitions: bus width, default depth and pointer width.
// Imported by the CU, the datapath and the hardware stack.
package epmp_hw_stack_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned SP_W   = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/epmp_stack_ram.sv
// Stack storage: one synchronous write port and one asynchronous read port.
// Intended to map onto distributed RAM; contents are not reset.
module epmp_stack_ram
    import epmp_hw_stack_pkg::*;
#(
    parameter int unsigned DATA_W_P = DATA_W,
    parameter int unsigned DEPTH_P  = DEPTH,
    parameter int unsigned AW       = $clog2(DEPTH_P)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W_P-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W_P-1:0] rdata
);

    logic [DATA_W_P-1:0] mem [DEPTH_P];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/epmp_hw_stack.sv
// EPMP hardware data stack: pointer, full/empty flags, sticky errors and
// Exec_En-gated push/pop commit around the epmp_stack_ram storage.
module epmp_hw_stack
    import epmp_hw_stack_pkg::*;
#(
    parameter int unsigned DATA_W_P = DATA_W,
    parameter int unsigned DEPTH_P  = DEPTH,
    parameter int unsigned SP_W_P   = $clog2(DEPTH_P) + 1
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                Exec_En,
    input  logic                Push_Stack,
    input  logic                Pop_Stack,
    input  logic [DATA_W_P-1:0] Din,
    output logic [DATA_W_P-1:0] Dout,
    output logic                Full,
    output logic                Empty,
    output logic                Ovf,
    output logic                Unf,
    input  logic                Clear_Err,
    output logic [SP_W_P-1:0]   Debug_SP
);

    localparam int unsigned AW = SP_W_P - 1;

    logic [SP_W_P-1:0]   sp, sp_nxt;
    logic                ovf_set, unf_set;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       tos_addr;
    logic [DATA_W_P-1:0] tos_data;

    assign Full     = (sp == SP_W_P'(DEPTH_P));
    assign Empty    = (sp == '0);
    assign tos_addr = AW'(sp - SP_W_P'(1));
    assign Dout     = Empty ? '0 : tos_data;
    assign Debug_SP = sp;

    always_comb begin
        sp_nxt  = sp;
        wr_en   = 1'b0;
        wr_addr = AW'(sp);
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (Exec_En) begin
            unique case (decode_op(Push_Stack, Pop_Stack))
                OP_PUSH: begin
                    if (Full) ovf_set = 1'b1;
                    else begin
                        wr_en  = 1'b1;
                        sp_nxt = sp + SP_W_P'(1);
                    end
                end
                OP_POP: begin
                    if (Empty) unf_set = 1'b1;
                    else       sp_nxt  = sp - SP_W_P'(1);
                end
                // Replace TOS in place; on an empty stack this degrades to a push.
                OP_REPL: begin
                    wr_en = 1'b1;
                    if (Empty) sp_nxt  = sp + SP_W_P'(1);
                    else       wr_addr = tos_addr;
                end
                default: ;
            endcase
        end
        // A reset held across an edge must not leave a stray write behind.
        if (!nReset) wr_en = 1'b0;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sp  <= '0;
            Ovf <= 1'b0;
            Unf <= 1'b0;
        end else begin
            sp  <= sp_nxt;
            Ovf <= (Ovf & ~Clear_Err) | ovf_set;
            Unf <= (Unf & ~Clear_Err) | unf_set;
        end
    end

    epmp_stack_ram #(
        .DATA_W_P (DATA_W_P),
        .DEPTH_P  (DEPTH_P),
        .AW       (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (Din),
        .raddr (tos_addr),
        .rdata (tos_data)
    );

endmodule

// File: tb/tb_epmp_hw_stack.sv
// Directed self-checking bench for epmp_hw_stack with hand-computed expectations.
module tb_epmp_hw_stack;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       Exec_En = 1'b0;
    logic       Push_Stack = 1'b0;
    logic       Pop_Stack = 1'b0;
    logic [7:0] Din = '0;
    logic [7:0] Dout;
    logic       Full, Empty, Ovf, Unf;
    logic       Clear_Err = 1'b0;
    logic [4:0] Debug_SP;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    epmp_hw_stack dut (
        .clk        (clk),
        .nReset     (nReset),
        .Exec_En    (Exec_En),
        .Push_Stack (Push_Stack),
        .Pop_Stack  (Pop_Stack),
        .Din        (Din),
        .Dout       (Dout),
        .Full       (Full),
        .Empty      (Empty),
        .Ovf        (Ovf),
        .Unf        (Unf),
        .Clear_Err  (Clear_Err),
        .Debug_SP   (Debug_SP)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of strobes, then return 1 ns after the committing edge.
    task automatic cycle(input logic push, input logic pop, input logic [7:0] d, input logic en);
        Push_Stack = push;
        Pop_Stack  = pop;
        Din        = d;
        Exec_En    = en;
        @(posedge clk);
        #1;
        Push_Stack = 1'b0;
        Pop_Stack  = 1'b0;
        Exec_En    = 1'b0;
    endtask

    task automatic do_reset();
        #2 nReset = 1'b0;
        @(posedge clk);
        #1 nReset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk); #1;
        check_eq("rst_sp",    Debug_SP, 0);
        check_eq("rst_empty", Empty, 1);
        check_eq("rst_full",  Full, 0);
        check_eq("rst_dout",  Dout, 0);
        check_eq("rst_ovf",   Ovf, 0);
        check_eq("rst_unf",   Unf, 0);
        nReset = 1'b1;

        // 1: push three, pop one
        cycle(1, 0, 8'h11, 1);
        cycle(1, 0, 8'h22, 1);
        cycle(1, 0, 8'h33, 1);
        check_eq("t1_sp3",   Debug_SP, 3);
        check_eq("t1_tos33", Dout, 8'h33);
        Pop_Stack = 1'b1; Exec_En = 1'b1; #1;
        check_eq("t1_popcyc", Dout, 8'h33);
        @(posedge clk); #1;
        Pop_Stack = 1'b0; Exec_En = 1'b0;
        check_eq("t1_tos22", Dout, 8'h22);
        check_eq("t1_sp2",   Debug_SP, 2);

        // 2: held push strobe, only one enabled cycle commits
        do_reset();
        for (int i = 0; i < 4; i++) begin
            Push_Stack = 1'b1; Din = 8'hA5; Exec_En = (i == 2);
            @(posedge clk); #1;
        end
        Push_Stack = 1'b0; Exec_En = 1'b0;
        check_eq("t2_sp1",   Debug_SP, 1);
        check_eq("t2_tosA5", Dout, 8'hA5);
        cycle(0, 1, 8'h00, 0);
        check_eq("t2_pop_noen", Debug_SP, 1);

        // 3: fill to DEPTH then overflow
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i), 1);
        check_eq("t3_full",  Full, 1);
        check_eq("t3_sp16",  Debug_SP, 16);
        check_eq("t3_ovf0",  Ovf, 0);
        cycle(1, 0, 8'hFF, 1);
        check_eq("t3_ovf1",  Ovf, 1);
        check_eq("t3_sp_sat", Debug_SP, 16);
        check_eq("t3_tos0F", Dout, 8'h0F);
        cycle(0, 1, 8'h00, 1);
        check_eq("t3_tos0E", Dout, 8'h0E);
        check_eq("t3_notfull", Full, 0);
        check_eq("t3_ovf_sticky", Ovf, 1);

        // 4: underflow, clear, set-wins, clear ignoring Exec_En
        do_reset();
        cycle(0, 1, 8'h00, 1);
        check_eq("t4_unf1",  Unf, 1);
        check_eq("t4_sp0",   Debug_SP, 0);
        check_eq("t4_dout0", Dout, 0);
        Clear_Err = 1'b1;
        cycle(0, 0, 8'h00, 0);
        Clear_Err = 1'b0;
        check_eq("t4_clr",   Unf, 0);
        Clear_Err = 1'b1;
        cycle(0, 1, 8'h00, 1);
        Clear_Err = 1'b0;
        check_eq("t4_setwins", Unf, 1);

        // 5: simultaneous push and pop replaces TOS
        do_reset();
        cycle(1, 0, 8'h10, 1);
        cycle(1, 0, 8'h20, 1);
        cycle(1, 1, 8'h99, 1);
        check_eq("t5_sp2",   Debug_SP, 2);
        check_eq("t5_tos99", Dout, 8'h99);
        check_eq("t5_unf0",  Unf, 0);
        cycle(0, 1, 8'h00, 1);
        check_eq("t5_tos10", Dout, 8'h10);
        check_eq("t5_sp1",   Debug_SP, 1);

        // 5b: push and pop on an empty stack acts as a plain push
        do_reset();
        cycle(1, 1, 8'h5C, 1);
        check_eq("t5b_sp1",  Debug_SP, 1);
        check_eq("t5b_tos",  Dout, 8'h5C);
        check_eq("t5b_unf0", Unf, 0);

        // 6: asynchronous reset mid-cycle
        do_reset();
        cycle(0, 1, 8'h00, 1);
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h40 + i), 1);
        check_eq("t6_sp5",  Debug_SP, 5);
        check_eq("t6_unf1", Unf, 1);
        #2 nReset = 1'b0;
        #1;
        check_eq("t6_sp0",   Debug_SP, 0);
        check_eq("t6_empty", Empty, 1);
        check_eq("t6_ovf",   Ovf, 0);
        check_eq("t6_unf",   Unf, 0);
        check_eq("t6_dout",  Dout, 0);
        @(posedge clk); #1 nReset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
